alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the combinational datapath ALU: registered result and flags,

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_shift_unit.sv | 60 ++++++
 rtl/alu_seq.sv | 193 +++++++++++++++++++
 tb/tb_alu_seq.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode and FSM state enums and a
// helper that classifies the multi-cycle shift/rotate opcodes.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_INC   = 4'h2,
    OP_DEC   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_NOT   = 4'h7,
    OP_SHL   = 4'h8,
    OP_SHR   = 4'h9,
    OP_ROL   = 4'hA,
    OP_ROR   = 4'hB,
    OP_PAR   = 4'hC,
    OP_CMP   = 4'hD,
    OP_PASSB = 4'hE,
    OP_RSV   = 4'hF
  } alu_op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic logic OP_IS_SHIFT(input alu_op_e o);
    return (o == OP_SHL) || (o == OP_SHR) || (o == OP_ROL) || (o == OP_ROR);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative shifter/rotator: moves the operand one bit per step while a
// down-counter runs from the loaded amount to 1. The next operand value and
// the bit leaving the word are exposed combinationally so the owner can
// capture the final step directly into its output register.
module alu_shift_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_left,
  input  logic               i_rot,
  input  logic [WIDTH-1:0]   i_opnd,
  input  logic [SHAMT_W-1:0] i_amt,
  output logic               o_last,
  output logic [WIDTH-1:0]   o_nxt,
  output logic               o_nxt_carry
);

  logic [WIDTH-1:0]   r_opnd;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_left;
  logic               r_rot;

  // One-bit step; rotates feed the leaving bit back in, shifts feed zero.
  always_comb begin
    o_nxt       = '0;
    o_nxt_carry = 1'b0;
    if (r_left) begin
      o_nxt       = {r_opnd[WIDTH-2:0], r_rot ? r_opnd[WIDTH-1] : 1'b0};
      o_nxt_carry = r_opnd[WIDTH-1];
    end else begin
      o_nxt       = {r_rot ? r_opnd[0] : 1'b0, r_opnd[WIDTH-1:1]};
      o_nxt_carry = r_opnd[0];
    end
  end

  assign o_last = (r_cnt == SHAMT_W'(1));

  // Operand/counter/control registers: load on accept, advance while shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opnd <= '0;
      r_cnt  <= '0;
      r_left <= 1'b0;
      r_rot  <= 1'b0;
    end else if (i_load) begin
      r_opnd <= i_opnd;
      r_cnt  <= i_amt;
      r_left <= i_left;
      r_rot  <= i_rot;
    end else if (i_step) begin
      r_opnd <= o_nxt;
      r_cnt  <= r_cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with registered result/flags. Single-cycle ops
// are computed here; non-zero shifts/rotates run in alu_shift_unit.
// Optional build macro ALU_SAT_EN: signed saturation of ADD/SUB/INC/DEC.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rslt,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             ovf,
  output logic             busy
);

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  alu_op_e            w_op;
  state_e             r_state, w_state_nxt;
  logic               w_accept;
  logic [WIDTH-1:0]   w_opb;
  logic [WIDTH:0]     w_add, w_sub;
  logic               w_add_ovf, w_sub_ovf;
  logic [SHAMT_W-1:0] w_sh, w_rot_amt, w_amt;
  logic [WIDTH-1:0]   w_res, w_fval;
  logic               w_c, w_ovf, w_noflags, w_start_sh;
  logic               w_sh_last, w_sh_carry, w_shift_done;
  logic [WIDTH-1:0]   w_sh_res;
  logic [WIDTH-1:0]   r_rslt;
  logic               r_out_valid, r_zero, r_carry, r_neg, r_ovf;
`ifdef ALU_SAT_EN
  logic [WIDTH-1:0]   w_sat;
`endif

  assign w_op      = alu_op_e'(op);
  assign w_accept  = in_valid && in_ready;
  assign w_opb     = (w_op == OP_INC || w_op == OP_DEC) ? WIDTH'(1) : in_b;
  assign w_add     = {1'b0, in_a} + {1'b0, w_opb};
  assign w_sub     = {1'b0, in_a} - {1'b0, w_opb};  // MSB is the borrow
  assign w_add_ovf = (in_a[WIDTH-1] == w_opb[WIDTH-1]) && (w_add[WIDTH-1] != in_a[WIDTH-1]);
  assign w_sub_ovf = (in_a[WIDTH-1] != w_opb[WIDTH-1]) && (w_sub[WIDTH-1] != in_a[WIDTH-1]);
  assign w_sh      = in_b[SHAMT_W-1:0];
  assign w_rot_amt = SHAMT_W'(in_b % WIDTH_V);
`ifdef ALU_SAT_EN
  // Overflow always lands on the side given by A's sign.
  assign w_sat = in_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif

  // Single-cycle datapath and shift launch decision.
  always_comb begin
    w_res      = '0;
    w_c        = 1'b0;
    w_ovf      = 1'b0;
    w_noflags  = 1'b0;
    w_start_sh = 1'b0;
    w_amt      = '0;
    case (w_op)
      OP_ADD, OP_INC: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_ovf = w_add_ovf;
`ifdef ALU_SAT_EN
        if (w_add_ovf) w_res = w_sat;
`endif
      end
      OP_SUB, OP_DEC: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_ovf = w_sub_ovf;
`ifdef ALU_SAT_EN
        if (w_sub_ovf) w_res = w_sat;
`endif
      end
      OP_AND: w_res = in_a & in_b;
      OP_OR:  w_res = in_a | in_b;
      OP_XOR: w_res = in_a ^ in_b;
      OP_NOT: w_res = ~in_a;
      OP_SHL, OP_SHR: begin
        if (in_b >= WIDTH_V) w_res = '0;
        else if (w_sh == '0) w_res = in_a;
        else begin
          w_start_sh = 1'b1;
          w_amt      = w_sh;
        end
      end
      OP_ROL, OP_ROR: begin
        if (w_rot_amt == '0) w_res = in_a;
        else begin
          w_start_sh = 1'b1;
          w_amt      = w_rot_amt;
        end
      end
      OP_PAR: w_res = {{(WIDTH-1){1'b0}}, ^in_a};
      OP_CMP: begin
        w_res = in_a;
        w_c   = w_sub[WIDTH];
        w_ovf = w_sub_ovf;
      end
      OP_PASSB: w_res = in_b;
      default: w_noflags = 1'b1;
    endcase
    // CMP reports zero/neg of the difference, not of the passed-through A.
    w_fval = (w_op == OP_CMP) ? w_sub[WIDTH-1:0] : w_res;
  end

  alu_shift_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_accept && w_start_sh),
    .i_step      (r_state == SHIFT),
    .i_left      (w_op == OP_SHL || w_op == OP_ROL),
    .i_rot       (w_op == OP_ROL || w_op == OP_ROR),
    .i_opnd      (in_a),
    .i_amt       (w_amt),
    .o_last      (w_sh_last),
    .o_nxt       (w_sh_res),
    .o_nxt_carry (w_sh_carry)
  );

  assign w_shift_done = (r_state == SHIFT) && w_sh_last;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state plus handshake/busy outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !r_out_valid || out_ready;
        if (in_valid && in_ready && w_start_sh) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_sh_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output register: load on single-cycle accept or final shift step,
  // otherwise drop valid once the consumer pops it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_rslt      <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_neg       <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_accept && !w_start_sh) begin
      r_out_valid <= 1'b1;
      r_rslt      <= w_res;
      r_zero      <= !w_noflags && (w_fval == '0);
      r_carry     <= w_c;
      r_neg       <= !w_noflags && w_fval[WIDTH-1];
      r_ovf       <= w_ovf;
    end else if (w_shift_done) begin
      r_out_valid <= 1'b1;
      r_rslt      <= w_sh_res;
      r_zero      <= (w_sh_res == '0);
      r_carry     <= w_sh_carry;
      r_neg       <= w_sh_res[WIDTH-1];
      r_ovf       <= 1'b0;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign rslt      = r_rslt;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign neg       = r_neg;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): reset, arithmetic/logic flags,
// multi-cycle shift latency, backpressure, back-to-back and reset mid-shift.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = 4'h0;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] rslt;
  logic       zero, carry, neg, ovf, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .rslt(rslt), .zero(zero), .carry(carry),
    .neg(neg), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Present an op, wait for in_ready, return 1ns after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    op = o; in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL issue_timeout op=%h in_ready never rose", o);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Cycles from accept until out_valid (1 = next cycle); counts busy cycles.
  task automatic wait_result(output int lat, output int bcnt);
    lat = 1; bcnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if ({rslt, zero, carry, neg, ovf} !== 12'h0) begin
      errors++; $display("FAIL rst_outputs rslt=%h z%b c%b n%b o%b want all 0", rslt, zero, carry, neg, ovf); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arith;
    int lat, bc;
    issue(4'h0, 8'hF0, 8'h20);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency out_valid %b want 1", out_valid); end
    checks++; if ({rslt, carry, zero, ovf, neg} !== {8'h10, 4'b1000}) begin
      errors++; $display("FAIL add_f0_20 rslt=%h c%b z%b o%b n%b want 10 c1 z0 o0 n0", rslt, carry, zero, ovf, neg); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_drop out_valid %b want 0", out_valid); end

    issue(4'h1, 8'h05, 8'h05); wait_result(lat, bc);
    checks++; if ({rslt, zero, carry} !== {8'h00, 2'b10}) begin
      errors++; $display("FAIL sub_05_05 rslt=%h z%b c%b want 00 z1 c0", rslt, zero, carry); end

    issue(4'hC, 8'h07, 8'h00); wait_result(lat, bc);
    checks++; if (rslt !== 8'h01) begin errors++; $display("FAIL par_07 rslt=%h want 01", rslt); end

    issue(4'hD, 8'h03, 8'h05); wait_result(lat, bc);
    checks++; if ({rslt, carry, neg, zero, ovf} !== {8'h03, 4'b1100}) begin
      errors++; $display("FAIL cmp_03_05 rslt=%h c%b n%b z%b o%b want 03 c1 n1 z0 o0", rslt, carry, neg, zero, ovf); end

    issue(4'h3, 8'h00, 8'h00); wait_result(lat, bc);
    checks++; if ({rslt, carry, neg, ovf} !== {8'hFF, 3'b110}) begin
      errors++; $display("FAIL dec_00 rslt=%h c%b n%b o%b want ff c1 n1 o0", rslt, carry, neg, ovf); end

    issue(4'h7, 8'hA5, 8'h00); wait_result(lat, bc);
    checks++; if (rslt !== 8'h5A) begin errors++; $display("FAIL not_a5 rslt=%h want 5a", rslt); end

    issue(4'hF, 8'hFF, 8'hFF); wait_result(lat, bc);
    checks++; if ({rslt, zero, carry, neg, ovf} !== 12'h0) begin
      errors++; $display("FAIL reserved rslt=%h z%b c%b n%b o%b want all 0", rslt, zero, carry, neg, ovf); end

    issue(4'h0, 8'h70, 8'h20); wait_result(lat, bc);
`ifdef ALU_SAT_EN
    checks++; if ({rslt, ovf, neg} !== {8'h7F, 2'b10}) begin
      errors++; $display("FAIL add_sat rslt=%h o%b n%b want 7f o1 n0", rslt, ovf, neg); end
`else
    checks++; if ({rslt, ovf, neg} !== {8'h90, 2'b11}) begin
      errors++; $display("FAIL add_wrap rslt=%h o%b n%b want 90 o1 n1", rslt, ovf, neg); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_shift;
    int lat, bc;
    issue(4'h8, 8'h81, 8'h03); wait_result(lat, bc);
    checks++; if (lat != 4 || bc != 3) begin errors++; $display("FAIL shl_timing lat=%0d busy=%0d want 4/3", lat, bc); end
    checks++; if ({rslt, carry} !== {8'h08, 1'b0}) begin errors++; $display("FAIL shl_81_3 rslt=%h c%b want 08 c0", rslt, carry); end

    issue(4'hA, 8'h81, 8'h09); wait_result(lat, bc);
    checks++; if (lat != 2) begin errors++; $display("FAIL rol_latency lat=%0d want 2", lat); end
    checks++; if ({rslt, carry} !== {8'h03, 1'b1}) begin errors++; $display("FAIL rol_81_9 rslt=%h c%b want 03 c1", rslt, carry); end

    issue(4'h9, 8'h81, 8'h02); wait_result(lat, bc);
    checks++; if (lat != 3 || {rslt, carry} !== {8'h20, 1'b0}) begin
      errors++; $display("FAIL shr_81_2 lat=%0d rslt=%h c%b want 3 20 c0", lat, rslt, carry); end

    issue(4'hB, 8'h01, 8'h01); wait_result(lat, bc);
    checks++; if ({rslt, carry, neg} !== {8'h80, 2'b11}) begin
      errors++; $display("FAIL ror_01_1 rslt=%h c%b n%b want 80 c1 n1", rslt, carry, neg); end

    issue(4'h9, 8'h81, 8'h08); wait_result(lat, bc);
    checks++; if (lat != 1 || {rslt, carry, zero} !== {8'h00, 2'b01}) begin
      errors++; $display("FAIL shr_overrange lat=%0d rslt=%h c%b z%b want 1 00 c0 z1", lat, rslt, carry, zero); end

    issue(4'h8, 8'hC3, 8'h00); wait_result(lat, bc);
    checks++; if (lat != 1 || {rslt, carry} !== {8'hC3, 1'b0}) begin
      errors++; $display("FAIL shl_zero lat=%0d rslt=%h c%b want 1 c3 c0", lat, rslt, carry); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    issue(4'h0, 8'h01, 8'h02);
    op = 4'h0; in_a = 8'h10; in_b = 8'h01; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1 || rslt !== 8'h03 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] ov%b rslt=%h ir%b want 1 03 0", k, out_valid, rslt, in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release in_ready %b want 1", in_ready); end
    @(posedge clk); #1; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || rslt !== 8'h11) begin
      errors++; $display("FAIL bp_next ov%b rslt=%h want 1 11", out_valid, rslt); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int c0;
    issue(4'h0, 8'h01, 8'h01);
    c0 = cyc;
    issue(4'h6, 8'hF0, 8'hFF);
    checks++; if (cyc - c0 != 1 || rslt !== 8'h0F || out_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_xor cycles=%0d rslt=%h ov%b want 1 0f 1", cyc - c0, rslt, out_valid); end
    c0 = cyc;
    issue(4'h7, 8'h0F, 8'h00);
    checks++; if (cyc - c0 != 1 || rslt !== 8'hF0) begin
      errors++; $display("FAIL b2b_not cycles=%0d rslt=%h want 1 f0", cyc - c0, rslt); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift;
    int seen;
    seen = 0;
    issue(4'hB, 8'h80, 8'h06);
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ror_busy busy %b want 1", busy); end
    rst_n = 1'b0; #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid ov%b busy%b ir%b want 0 0 1", out_valid, busy, in_ready); end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL stale_result out_valid seen %0d cycles want 0", seen); end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_shift;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_shift;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
